sha256_block_builder: RTL and testbench

- Parametrised successor to the single-width chunk processor.
- Accepts a message context (byte address, byte length), fetches the message through a handshaked memory read port of configurable width, and assembles 512-bit SHA-256 blocks with full FIPS 180-4 padding.
- Handles the extra padding block when needed; tags first/last blocks.
- Sits between the context scheduler and the SHA-256 compression core.

---
 rtl/sha256_block_builder.sv | 206 ++++++++++++++++++++
 tb/tb_sha256_block_builder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_builder.sv
// Fetches a message through a pipelined read port and emits FIPS 180-4 padded
// 512-bit SHA-256 blocks, tagging the first and last block of each message.
module sha256_block_builder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctx_vld,
  output logic              ctx_rdy,
  input  logic [ADDR_W-1:0] ctx_addr,
  input  logic [LEN_W-1:0]  ctx_len,
  output logic              mem_req_vld,
  input  logic              mem_req_rdy,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_vld,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              chunk_vld,
  input  logic              chunk_rdy,
  output logic [511:0]      chunk_data,
  output logic              chunk_first,
  output logic              chunk_last,
  output logic              busy
);

  localparam int BPW  = DATA_W / 8;
  localparam int WPB  = 64 / BPW;
  localparam int LBPW = $clog2(BPW);
  localparam int SW   = $clog2(WPB);
  localparam int CW   = SW + 1;
  localparam int BW   = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  state_t            r_state, w_state_next;
  logic              r_ctx_rdy, r_busy, r_req_vld, r_chunk_vld, r_chunk_first, r_chunk_last;
  logic              w_ctx_rdy_next, w_busy_next, w_req_vld_next;
  logic              w_chunk_vld_next, w_chunk_first_next, w_chunk_last_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [BW-1:0]     r_nb, r_b, r_words_left;
  logic [CW-1:0]     r_blk_words, r_req_cnt, r_rsp_cnt;
  logic              r_first_cyc;
  logic [511:0]      r_buf;

  logic              w_accept, w_req_fire, w_rsp_take, w_out_hs, w_last_blk;
  logic [BW-1:0]     w_tw_in, w_nb_in;
  logic [CW-1:0]     w_blk_words_in, w_blk_words_nb, w_req_cnt_inc;
  logic [63:0]       w_len_bits;
  logic [7:0]        w_byte_next [64];

  function automatic logic [CW-1:0] f_blk_words(input logic [BW-1:0] left);
    return (left >= BW'(WPB)) ? CW'(WPB) : left[CW-1:0];
  endfunction

  assign w_accept       = (r_state == IDLE) && r_ctx_rdy && ctx_vld;
  assign w_req_fire     = r_req_vld && mem_req_rdy;
  // Only responses matching an outstanding request are captured.
  assign w_rsp_take     = (r_state == FETCH) && mem_rsp_vld && (r_rsp_cnt < r_req_cnt);
  assign w_out_hs       = (r_state == OUT) && chunk_rdy;
  assign w_last_blk     = (r_b == r_nb - BW'(1));
  assign w_tw_in        = ({1'b0, ctx_len} + BW'(BPW - 1)) >> LBPW;
  assign w_nb_in        = (({1'b0, ctx_len} + BW'(8)) >> 6) + BW'(1);
  assign w_blk_words_in = f_blk_words(w_tw_in);
  assign w_blk_words_nb = f_blk_words(r_words_left);
  assign w_req_cnt_inc  = r_req_cnt + CW'(w_req_fire);
  assign w_len_bits     = 64'({r_len, 3'b000});

  always_comb begin
    w_state_next   = r_state;
    w_req_vld_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next   = FETCH;
          w_req_vld_next = (w_blk_words_in != '0);
        end
      end
      FETCH: begin
        if ((r_first_cyc && r_blk_words == '0) ||
            (w_rsp_take && (r_rsp_cnt + CW'(1) == r_blk_words)))
          w_state_next = OUT;
        w_req_vld_next = (w_state_next == FETCH) && (w_req_cnt_inc < r_blk_words);
      end
      OUT: begin
        if (w_out_hs) begin
          w_state_next   = r_chunk_last ? IDLE : FETCH;
          w_req_vld_next = !r_chunk_last && (w_blk_words_nb != '0);
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_ctx_rdy_next     = (r_state == IDLE) && !w_accept;
    w_busy_next        = (w_state_next != IDLE);
    w_chunk_vld_next   = (w_state_next == OUT);
    w_chunk_first_next = (w_state_next == OUT) && (r_b == '0);
    w_chunk_last_next  = (w_state_next == OUT) && w_last_blk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ctx_rdy     <= 1'b0;
      r_busy        <= 1'b0;
      r_req_vld     <= 1'b0;
      r_chunk_vld   <= 1'b0;
      r_chunk_first <= 1'b0;
      r_chunk_last  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ctx_rdy     <= w_ctx_rdy_next;
      r_busy        <= w_busy_next;
      r_req_vld     <= w_req_vld_next;
      r_chunk_vld   <= w_chunk_vld_next;
      r_chunk_first <= w_chunk_first_next;
      r_chunk_last  <= w_chunk_last_next;
    end
  end

  // r_addr is the running request address, so it already holds the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_len        <= '0;
      r_nb         <= '0;
      r_b          <= '0;
      r_words_left <= '0;
      r_blk_words  <= '0;
      r_req_cnt    <= '0;
      r_rsp_cnt    <= '0;
      r_first_cyc  <= 1'b0;
      r_buf        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr       <= ctx_addr;
            r_len        <= ctx_len;
            r_nb         <= w_nb_in;
            r_b          <= '0;
            r_blk_words  <= w_blk_words_in;
            r_words_left <= w_tw_in - BW'(w_blk_words_in);
            r_req_cnt    <= '0;
            r_rsp_cnt    <= '0;
            r_first_cyc  <= 1'b1;
          end
        end
        FETCH: begin
          r_first_cyc <= 1'b0;
          if (w_req_fire) begin
            r_req_cnt <= w_req_cnt_inc;
            r_addr    <= r_addr + ADDR_W'(BPW);
          end
          if (w_rsp_take)
            r_rsp_cnt <= r_rsp_cnt + CW'(1);
        end
        OUT: begin
          if (w_out_hs && !r_chunk_last) begin
            r_b          <= r_b + BW'(1);
            r_blk_words  <= w_blk_words_nb;
            r_words_left <= r_words_left - BW'(w_blk_words_nb);
            r_req_cnt    <= '0;
            r_rsp_cnt    <= '0;
            r_first_cyc  <= 1'b1;
          end
        end
        default: r_first_cyc <= 1'b0;
      endcase
      for (int i = 0; i < 64; i++)
        r_buf[511-8*i -: 8] <= w_byte_next[i];
    end
  end

  // The first FETCH cycle preloads the padding pattern; captured words then
  // overwrite only bytes that lie inside the message, so 0x80 and length survive.
  for (genvar gi = 0; gi < 64; gi++) begin : g_lane
    localparam int SLOT = gi / BPW;
    localparam int POS  = gi % BPW;
    logic [BW-1:0] w_off;
    logic [7:0]    w_pad;
    logic          w_wr;

    assign w_off = {r_b[BW-7:0], 6'(gi)};
    if (gi >= 56) begin : g_len
      assign w_pad = w_last_blk ? w_len_bits[(63-gi)*8 +: 8] :
                     ((w_off == {1'b0, r_len}) ? 8'h80 : 8'h00);
    end else begin : g_msg
      assign w_pad = (w_off == {1'b0, r_len}) ? 8'h80 : 8'h00;
    end
    assign w_wr = w_rsp_take && (r_rsp_cnt[SW-1:0] == SW'(SLOT)) && (w_off < {1'b0, r_len});
    assign w_byte_next[gi] = r_first_cyc ? w_pad :
                             w_wr        ? mem_rsp_data[DATA_W-1-POS*8 -: 8] :
                                           r_buf[511-gi*8 -: 8];
  end

  assign ctx_rdy      = r_ctx_rdy;
  assign busy         = r_busy;
  assign mem_req_vld  = r_req_vld;
  assign mem_req_addr = r_addr;
  assign chunk_vld    = r_chunk_vld;
  assign chunk_first  = r_chunk_first;
  assign chunk_last   = r_chunk_last;
  assign chunk_data   = r_buf;

endmodule

// File: tb/tb_sha256_block_builder.sv
// Bench for sha256_block_builder: 32-bit and 128-bit instances, each with a
// random-latency memory model and a byte-stream padding reference model.
`timescale 1ns/1ps
module tb_sha256_block_builder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int DW  = (gi == 0) ? 32 : 128;
    localparam int BPW = DW / 8;
    localparam int WPB = 64 / BPW;

    logic          rst, ctx_vld, ctx_rdy, mem_req_vld, mem_req_rdy, mem_rsp_vld;
    logic          chunk_vld, chunk_rdy, chunk_first, chunk_last, busy;
    logic [31:0]   ctx_addr, ctx_len, mem_req_addr;
    logic [DW-1:0] mem_rsp_data;
    logic [511:0]  chunk_data;

    sha256_block_builder #(.ADDR_W(32), .DATA_W(DW), .LEN_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .ctx_vld(ctx_vld), .ctx_rdy(ctx_rdy), .ctx_addr(ctx_addr), .ctx_len(ctx_len),
      .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
      .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data),
      .chunk_vld(chunk_vld), .chunk_rdy(chunk_rdy), .chunk_data(chunk_data),
      .chunk_first(chunk_first), .chunk_last(chunk_last), .busy(busy)
    );

    logic [7:0]  mem [4096];
    int          rdy_mode = 0;
    int          lat = 1;
    int          spur_en = 0;
    int          cyc = 0;
    int          max_out = 0;
    logic [31:0] req_log[$];
    int          pend_due[$];
    logic [31:0] pend_addr[$];

    function automatic logic [DW-1:0] word_at(input logic [31:0] a);
      logic [DW-1:0] w;
      w = '0;
      for (int k = 0; k < BPW; k++) w[DW-1-8*k -: 8] = mem[12'(a + 32'(k))];
      return w;
    endfunction

    // Memory model: in-order responses after `lat` cycles, optional stray responses.
    initial begin
      mem_req_rdy  = 1'b0;
      mem_rsp_vld  = 1'b0;
      mem_rsp_data = '0;
      forever begin
        @(negedge clk);
        cyc++;
        mem_rsp_vld = 1'b0;
        if (rst) begin
          pend_due.delete();
          pend_addr.delete();
          mem_req_rdy = 1'b0;
        end else begin
          if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = word_at(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
          end else if (pend_due.size() == 0 && spur_en != 0 && $urandom_range(0, 3) == 0) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = DW'({$urandom, $urandom, $urandom, $urandom});
          end
          case (rdy_mode)
            0:       mem_req_rdy = 1'b1;
            1:       mem_req_rdy = ~mem_req_rdy;
            default: mem_req_rdy = 1'($urandom_range(0, 1));
          endcase
          if (mem_req_vld && mem_req_rdy) begin
            req_log.push_back(mem_req_addr);
            pend_due.push_back(cyc + lat);
            pend_addr.push_back(mem_req_addr);
            if (pend_due.size() > max_out) max_out = pend_due.size();
          end
        end
      end
    end

    task automatic run_msg(input logic [31:0] addr, input int len, input int hold,
                           output logic [511:0] obs_first, output logic [511:0] obs_last);
      logic [7:0]   pm[$];
      logic [511:0] exp_q[$];
      logic [511:0] blk;
      logic [63:0]  bits;
      int nb, tw, t, n;
      string pfx;
      pfx = $sformatf("dw%0d_len%0d", DW, len);
      obs_first = '0;
      obs_last  = '0;
      for (int o = 0; o < len; o++) pm.push_back(mem[12'(addr + 32'(o))]);
      pm.push_back(8'h80);
      while (pm.size() % 64 != 56) pm.push_back(8'h00);
      bits = 64'(len) * 64'd8;
      for (int k = 7; k >= 0; k--) pm.push_back(bits[8*k +: 8]);
      nb = pm.size() / 64;
      for (int j = 0; j < nb; j++) begin
        for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pm[j*64+i];
        exp_q.push_back(blk);
      end
      tw = (len + BPW - 1) / BPW;
      req_log.delete();
      max_out = 0;

      t = 0;
      while (!ctx_rdy && t < 200) begin @(negedge clk); t++; end
      check({pfx, "_ctx_rdy_idle"}, 512'(ctx_rdy), 512'(1));
      ctx_addr = addr;
      ctx_len  = 32'(len);
      ctx_vld  = 1'b1;
      @(negedge clk);
      ctx_vld = 1'b0;
      check({pfx, "_busy_accept"}, 512'(busy), 512'(1));
      check({pfx, "_ctx_rdy_accept"}, 512'(ctx_rdy), 512'(0));
      check({pfx, "_req_latency"}, 512'(mem_req_vld), 512'(tw > 0));

      for (int j = 0; j < nb; j++) begin
        t = 0;
        while (!chunk_vld && t < 2000) begin @(negedge clk); t++; end
        check($sformatf("%s_blk%0d_vld", pfx, j), 512'(chunk_vld), 512'(1));
        if (!chunk_vld) break;
        check($sformatf("%s_blk%0d_data", pfx, j), chunk_data, exp_q[j]);
        check($sformatf("%s_blk%0d_first", pfx, j), 512'(chunk_first), 512'(j == 0));
        check($sformatf("%s_blk%0d_last", pfx, j), 512'(chunk_last), 512'(j == nb - 1));
        if (j == 0) obs_first = chunk_data;
        if (j == nb - 1) obs_last = chunk_data;
        n = req_log.size();
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check($sformatf("%s_hold%0d_vld", pfx, h), 512'(chunk_vld), 512'(1));
          check($sformatf("%s_hold%0d_data", pfx, h), chunk_data, exp_q[j]);
          check($sformatf("%s_hold%0d_fl", pfx, h), 512'({chunk_first, chunk_last}),
                512'({j == 0, j == nb - 1}));
        end
        check($sformatf("%s_blk%0d_no_req_in_out", pfx, j), 512'(req_log.size()), 512'(n));
        chunk_rdy = 1'b1;
        @(negedge clk);
        chunk_rdy = 1'b0;
      end

      check({pfx, "_ctx_rdy_after_last"}, 512'(ctx_rdy), 512'(0));
      check({pfx, "_busy_after_last"}, 512'(busy), 512'(0));
      @(negedge clk);
      check({pfx, "_ctx_rdy_reopen"}, 512'(ctx_rdy), 512'(1));
      check({pfx, "_req_count"}, 512'(req_log.size()), 512'(tw));
      for (int i = 0; i < req_log.size() && i < tw; i++)
        check($sformatf("%s_addr%0d", pfx, i), 512'(req_log[i]), 512'(addr + 32'(i * BPW)));
      check({pfx, "_max_outstanding"}, 512'(max_out <= WPB), 512'(1));
      $display("msg dw=%0d addr=%h len=%0d blocks=%0d reqs=%0d", DW, addr, len, nb, req_log.size());
    endtask

    initial begin
      logic [511:0] f, l;
      int lens_tab[12];
      int len, t;
      logic [31:0] a;
      lens_tab = '{0, 1, 3, 55, 56, 57, 63, 64, 65, 119, 120, 128};
      rst = 1'b1; ctx_vld = 1'b0; chunk_rdy = 1'b0; ctx_addr = '0; ctx_len = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      check("rst_outputs", 512'({ctx_rdy, busy, mem_req_vld, chunk_vld, chunk_first, chunk_last}), 512'(0));
      check("rst_chunk_data", chunk_data, 512'(0));
      check("rst_req_addr", 512'(mem_req_addr), 512'(0));
      rst = 1'b0;
      @(negedge clk);
      check("ctx_rdy_after_rst", 512'(ctx_rdy), 512'(1));

      run_msg(32'h0000_0040, 0, 0, f, l);
      check("len0_block", l, {8'h80, 504'h0});

      if (DW == 32) begin
        mem[12'h100] = 8'h61; mem[12'h101] = 8'h62; mem[12'h102] = 8'h63; mem[12'h103] = 8'h00;
        run_msg(32'h0000_0100, 3, 0, f, l);
        check("abc_head", 512'(l[511:480]), 512'(32'h6162_6380));
        check("abc_tail", 512'(l[63:0]), 512'(64'h18));
        run_msg(32'h0000_0200, 56, 0, f, l);
        check("len56_blk1", l, 512'h1C0);
        rdy_mode = 1; lat = 3;
        run_msg(32'h0000_0300, 64, 0, f, l);
        check("len64_blk1", l, {8'h80, 440'h0, 64'h200});
        rdy_mode = 0; lat = 1;
        run_msg(32'h0000_0400, 20, 10, f, l);
      end else begin
        run_msg(32'h0000_0500, 100, 0, f, l);
        check("len100_mask", 512'(l[223:128]), 512'({8'h80, 88'h0}));
        ctx_addr = 32'h0000_0600; ctx_len = 32'd100; ctx_vld = 1'b1;
        @(negedge clk);
        ctx_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstpulse_outputs", 512'({ctx_rdy, busy, mem_req_vld, chunk_vld}), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstpulse_ctx_rdy", 512'(ctx_rdy), 512'(1));
        run_msg(32'h0000_0600, 100, 2, f, l);
      end

      for (int r = 0; r < 14; r++) begin
        len      = ($urandom_range(0, 1) == 0) ? lens_tab[$urandom_range(0, 11)] : int'($urandom_range(0, 300));
        a        = $urandom_range(0, 4095) & ~32'(BPW - 1);
        rdy_mode = $urandom_range(0, 2);
        lat      = $urandom_range(1, 4);
        spur_en  = $urandom_range(0, 1);
        t        = $urandom_range(0, 3);
        run_msg(a, len, t, f, l);
      end
      spur_en = 0;
      n_done++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (n_done < 2 && t < 80000) begin @(posedge clk); t++; end
    check("watchdog_done", 512'(n_done), 512'(2));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
